// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request/response and RGB332 video bundle of vga_timing_gen.
// tp_sel is present only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(parameter int CW = 10);
    logic [2:0]    px_red;
    logic [2:0]    px_green;
    logic [1:0]    px_blue;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          req;
    logic          h_sync;
    logic          v_sync;
    logic [2:0]    red;
    logic [2:0]    green;
    logic [1:0]    blue;
    logic          de;
    logic          frame_start;
    logic          line_start;
`ifdef VGA_TEST_PATTERN_EN
    logic          tp_sel;
    modport master (
        input  px_red, px_green, px_blue, tp_sel,
        output x, y, req, h_sync, v_sync, red, green, blue, de, frame_start, line_start
    );
    modport slave (
        output px_red, px_green, px_blue, tp_sel,
        input  x, y, req, h_sync, v_sync, red, green, blue, de, frame_start, line_start
    );
`else
    modport master (
        input  px_red, px_green, px_blue,
        output x, y, req, h_sync, v_sync, red, green, blue, de, frame_start, line_start
    );
    modport slave (
        output px_red, px_green, px_blue,
        input  x, y, req, h_sync, v_sync, red, green, blue, de, frame_start, line_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel request and 2-cycle RGB332 return path.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN (adds tp_sel).
module vga_timing_gen #(
    parameter int H_ADDR = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ADDR = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0,
    parameter int CW     = 10
) (
    input logic              pixel_clock,
    input logic              reset,
    vga_timing_gen_if.master vif
);
    localparam logic [CW-1:0] H_MAX  = CW'(H_ADDR + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_MAX  = CW'(V_ADDR + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ADDR);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ADDR);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ADDR + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ADDR + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ADDR + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ADDR + V_FP + V_SYNC - 1);

    logic [CW-1:0] r_hc, r_vc, r_x, r_y;
    logic [4:0]    r_c1, r_c2;
    logic          r_hs, r_vs, r_de, r_fs, r_ls;
    logic [7:0]    r_rgb;
    logic          w_h_end, w_v_end, w_act, w_hs, w_vs, w_fs, w_ls;
    logic [7:0]    w_src;

    assign w_h_end = r_hc == H_MAX;
    assign w_v_end = r_vc == V_MAX;
    assign w_act   = (r_hc < H_ACT) && (r_vc < V_ACT);
    assign w_hs    = (r_hc >= HS_BEG) && (r_hc <= HS_END);
    assign w_vs    = (r_vc >= VS_BEG) && (r_vc <= VS_END);
    assign w_fs    = (r_hc == '0) && (r_vc == '0);
    assign w_ls    = (r_hc == '0) && (r_vc < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
    logic [CW-1:0] r_x2;
    logic [2:0]    w_bar;
    assign w_bar = 3'({r_x2, 3'b000} / (CW+3)'(H_ADDR));
    assign w_src = vif.tp_sel ? {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}}
                              : {vif.px_red, vif.px_green, vif.px_blue};
    always_ff @(posedge pixel_clock)
        r_x2 <= reset ? '0 : r_x;
`else
    assign w_src = {vif.px_red, vif.px_green, vif.px_blue};
`endif

    // control bits {hs, vs, de, fs, ls} ride two stages so they meet the returned pixel
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_hc  <= '0;
            r_vc  <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_c1  <= '0;
            r_c2  <= '0;
            r_hs  <= ~H_POL;
            r_vs  <= ~V_POL;
            r_de  <= 1'b0;
            r_fs  <= 1'b0;
            r_ls  <= 1'b0;
            r_rgb <= 8'h00;
        end else begin
            r_hc  <= w_h_end ? '0 : r_hc + 1'b1;
            r_vc  <= w_h_end ? (w_v_end ? '0 : r_vc + 1'b1) : r_vc;
            r_x   <= r_hc;
            r_y   <= r_vc;
            r_c1  <= {w_hs, w_vs, w_act, w_fs, w_ls};
            r_c2  <= r_c1;
            r_hs  <= ~(r_c2[4] ^ H_POL);
            r_vs  <= ~(r_c2[3] ^ V_POL);
            r_de  <= r_c2[2];
            r_fs  <= r_c2[1];
            r_ls  <= r_c2[0];
            r_rgb <= r_c2[2] ? w_src : 8'h00;
        end
    end

    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.req         = r_c1[2];
    assign vif.h_sync      = r_hs;
    assign vif.v_sync      = r_vs;
    assign vif.de          = r_de;
    assign vif.frame_start = r_fs;
    assign vif.line_start  = r_ls;
    assign vif.red         = r_rgb[7:5];
    assign vif.green       = r_rgb[4:2];
    assign vif.blue        = r_rgb[1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three geometries run in parallel against a pixel-index raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int HA   [3] = '{640, 8, 40};
    localparam int HF   [3] = '{16, 2, 4};
    localparam int HS   [3] = '{96, 2, 8};
    localparam int HB   [3] = '{48, 2, 6};
    localparam int VA   [3] = '{480, 4, 20};
    localparam int VF   [3] = '{10, 1, 3};
    localparam int VS   [3] = '{2, 1, 2};
    localparam int VB   [3] = '{33, 1, 5};
    localparam bit HP   [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP   [3] = '{1'b0, 1'b1, 1'b0};
    localparam int CWS  [3] = '{10, 4, 6};
    localparam int LMIN [3] = '{800, 20, 300};
    localparam int LMAX [3] = '{2400, 300, 4000};
    localparam int NCYC = 22000;
`ifdef VGA_TEST_PATTERN_EN
    localparam int NMODE = 4;
`else
    localparam int NMODE = 3;
`endif

    typedef struct {
        int         x;
        int         y;
        logic       req;
        logic [12:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q [3][$];
    logic [9:0]  ox   [3];
    logic [9:0]  oy   [3];
    logic        oreq [3];
    logic [12:0] ov   [3];
    bit          done [3];
    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int HT = HA[g] + HF[g] + HS[g] + HB[g];
        localparam int VT = VA[g] + VF[g] + VS[g] + VB[g];
        logic       rst;
        logic [7:0] rtab [0:1023];
        int         mode;

        vga_timing_gen_if #(.CW(CWS[g])) vif ();
        vga_timing_gen #(
            .H_ADDR(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
            .V_ADDR(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
            .H_POL(HP[g]), .V_POL(VP[g]), .CW(CWS[g])
        ) dut (
            .pixel_clock(clk),
            .reset(rst),
            .vif(vif)
        );

        assign ox[g]   = 10'(vif.x);
        assign oy[g]   = 10'(vif.y);
        assign oreq[g] = vif.req;
        assign ov[g]   = {vif.h_sync, vif.v_sync, vif.de, vif.frame_start, vif.line_start,
                          vif.red, vif.green, vif.blue};

        // source data: 0 echo x, 1 constant FF, 2 random per-x table, 3 colour bars
        function automatic logic [7:0] ref_px(int m, int h);
            int b;
            b = h * 8 / HA[g];
            return m == 0 ? 8'(h) : m == 1 ? 8'hFF : m == 2 ? rtab[h]
                 : {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
        endfunction

        // j = edges since the last edge that sampled reset high
        function automatic exp_t model(int j, int m);
            exp_t e;
            int p, h, v;
            logic de, hs, vs;
            e.x = 0;
            e.y = 0;
            e.req = 1'b0;
            e.v = {~HP[g], ~VP[g], 11'b0};
            if (j > 0) begin
                p = j - 1;
                e.x = p % HT;
                e.y = (p / HT) % VT;
                e.req = e.x < HA[g] && e.y < VA[g];
            end
            if (j > 2) begin
                p = j - 3;
                h = p % HT;
                v = (p / HT) % VT;
                de = h < HA[g] && v < VA[g];
                hs = h >= HA[g] + HF[g] && h < HA[g] + HF[g] + HS[g];
                vs = v >= VA[g] + VF[g] && v < VA[g] + VF[g] + VS[g];
                e.v = {hs ? HP[g] : ~HP[g], vs ? VP[g] : ~VP[g], de, h == 0 && v == 0,
                       h == 0 && v < VA[g], de ? ref_px(m, h) : 8'h00};
            end
            return e;
        endfunction

        initial begin : stim
            int j, ph, cyc, len, rl, last_x, m_next;
            logic [7:0] b;
            rst = 1'b1;
            mode = 1;
            last_x = 0;
            {vif.px_red, vif.px_green, vif.px_blue} = 8'hFF;
`ifdef VGA_TEST_PATTERN_EN
            vif.tp_sel = 1'b0;
`endif
            for (int i = 0; i < 1024; i++) rtab[i] = 8'($urandom);
            j = 0;
            cyc = 0;
            ph = 0;
            while (cyc < NCYC) begin
                rl = ph == 0 ? 4 : (g == 0 && ph == 1) ? 1 : int'($urandom_range(1, 3));
                len = (g == 0 && ph == 0) ? 16300 : int'($urandom_range(LMIN[g], LMAX[g]));
                m_next = ph == 0 ? 1 : int'($urandom_range(0, NMODE - 1));
                for (int k = 0; k < rl + len; k++) begin
                    rst = k < rl;
                    @(posedge clk);
                    j = rst ? 0 : j + 1;
                    if (k == 0) mode = m_next;
                    q[g].push_back(model(j, mode));
                    #1;
                    b = mode == 3 ? 8'($urandom) : ref_px(mode, last_x);
                    {vif.px_red, vif.px_green, vif.px_blue} = b;
`ifdef VGA_TEST_PATTERN_EN
                    vif.tp_sel = mode == 3;
`endif
                    last_x = int'(vif.x);
                    cyc++;
                end
                ph++;
            end
            done[g] = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            if (q[c].size() > 0) begin
                e = q[c].pop_front();
                checks++;
                if (ox[c] !== 10'(e.x) || oy[c] !== 10'(e.y) || oreq[c] !== e.req) begin
                    failures++;
                    $display("FAIL cfg%0d position t=%0t got x=%0d y=%0d req=%b want x=%0d y=%0d req=%b",
                             c, $time, ox[c], oy[c], oreq[c], e.x, e.y, e.req);
                end
                checks++;
                if (ov[c] !== e.v) begin
                    failures++;
                    $display("FAIL cfg%0d video t=%0t got hs,vs,de,fs,ls,rgb=%b want %b",
                             c, $time, ov[c], e.v);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        wait (done[0] && done[1] && done[2]);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q[0].size() + q[1].size() + q[2].size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", q[0].size() + q[1].size() + q[2].size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ADDR, 640, active pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync, back porch in pixel clocks.
REQ-003 Parameter V_ADDR, 480, active lines per frame.
REQ-004 Parameters V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync, back porch in lines.
REQ-005 Parameters H_POL 0, V_POL 0: sync polarity; 0 = asserted low, 1 = asserted high.
REQ-006 Parameter CW, 10, coordinate/counter width; SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-007 pixel_clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 px_red  in  3, px_green  in  3, px_blue  in  2  pixel data returned by the source.
REQ-010 x  out  CW, y  out  CW  coordinates of the requested pixel.
REQ-011 req  out  1  high when x,y address an active pixel.
REQ-012 h_sync  out  1, v_sync  out  1  sync outputs, polarity per H_POL/V_POL.
REQ-013 red  out  3, green  out  3, blue  out  2  RGB332 video output.
REQ-014 de  out  1  display enable, aligned with RGB.
REQ-015 frame_start  out  1, line_start  out  1  single-cycle pulses, aligned with RGB.

Function
REQ-016 H_TOTAL = H_ADDR+H_FP+H_SYNC+H_BP; V_TOTAL = V_ADDR+V_FP+V_SYNC+V_BP.
REQ-017 Counter hc SHALL step 0..H_TOTAL-1, then wrap to 0; vc SHALL increment only on the hc wrap cycle and wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-018 Line order: hc 0..H_ADDR-1 active, then FP, SYNC, BP; same order for vc.
REQ-019 x = hc and y = vc, registered; req = (hc < H_ADDR) && (vc < V_ADDR).
REQ-020 Source SHALL present px_* exactly one cycle after x,y,req; block registers px_* on the next edge.
REQ-021 h_sync, v_sync, de, frame_start, line_start SHALL be delayed 2 cycles from hc/vc so all outputs align with RGB for the same pixel.
REQ-022 Sync asserted when hc in [H_ADDR+H_FP, H_ADDR+H_FP+H_SYNC-1] (H), vc in [V_ADDR+V_FP, V_ADDR+V_FP+V_SYNC-1] (V).
REQ-023 When de is low, red/green/blue SHALL be 0 regardless of px_*.
REQ-024 frame_start high for the pixel at hc=0,vc=0; line_start high for every pixel hc=0 with vc < V_ADDR.
REQ-025 All comparisons SHALL be unsigned at CW bits; no combinational path from px_* to any output.

Reset
REQ-026 While reset is high at a rising edge: hc=vc=0, x=y=0, req=0, de=0, RGB=0, frame_start=line_start=0, h_sync=!H_POL, v_sync=!V_POL, pipeline cleared.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; first cycle after release restarts at hc=0,vc=0, first frame_start 2 cycles later.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN: when defined, input port tp_sel (1 bit) exists; tp_sel=1 replaces px_* with 8 vertical colour bars, bar index = x*8/H_ADDR, colour {bar[2]x3, bar[1]x3, bar[0]x2}, same 2-cycle latency.
REQ-029 When VGA_TEST_PATTERN_EN is undefined, tp_sel is absent and RGB always derives from px_*.

Verification
REQ-030 Defaults, px=8'hFF constant, run 2 frames -> h_sync period 800 clocks, low 96 clocks; v_sync period 420000 clocks, low 1600 clocks; de high 640 per active line.
REQ-031 px_* = x[7:0] echo from model with 1-cycle latency -> red/green/blue equal x[7:0] of the pixel 2 cycles earlier; blanking RGB = 0 while px=8'hFF.
REQ-032 Reset at hc=300,vc=200 for 1 cycle -> next cycle x=0,y=0; frame_start pulses 2 cycles after release; syncs deasserted during reset.
REQ-033 H_POL=1,V_POL=1, H_ADDR=8, H_FP=H_SYNC=H_BP=2, V_ADDR=4, V_FP=V_SYNC=V_BP=1 -> H_TOTAL 14, V_TOTAL 7, sync high-asserted, vc wraps 6->0 together with hc 13->0.
REQ-034 VGA_TEST_PATTERN_EN defined, tp_sel=1 -> x=0..79 outputs 8'h00, x=560..639 outputs 8'hFF; tp_sel=0 -> px_* passthrough.
